// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DIGIT = 4;

  // Digit counter width for a WIDTH/DIGIT slice schedule. A single-slice
  // schedule still keeps a 1-bit counter so the compare stays legal.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
    return ((width / digit) > 1) ? $clog2(width / digit) : 1;
  endfunction

  // Signed overflow of x - y. Operands of different sign can overflow, and
  // it shows as a result whose sign differs from the minuend.
  function automatic logic sub_overflow(input logic sign_x, input logic sign_y, input logic sign_r);
    return (sign_x != sign_y) && (sign_r != sign_x);
  endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// DIGIT-wide combinational ripple-carry slice: {cout, s} = x + y + cin.
module serial_sub_digit
  import serial_arith_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] w_c;

  // Bit-serial ripple across the slice.
  always_comb begin
    s      = '0;
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = x[i] ^ y[i] ^ w_c[i];
      w_c[i+1] = (x[i] & y[i]) | (x[i] & w_c[i]) | (y[i] & w_c[i]);
    end
    cout = w_c[DIGIT];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b computed as a + ~b + 1, DIGIT bits
// per clock LSB first through one slice with a registered carry.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST_CNT = CW'((WIDTH / DIGIT) - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("serial_subtractor: DIGIT must be a divisor of WIDTH");
  end

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_nb;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_overflow;
  logic [DIGIT-1:0] w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_acc_next;

  serial_sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x    (r_op_a[DIGIT-1:0]),
    .y    (r_op_nb[DIGIT-1:0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // New slice enters at the MSB end; after the last slice the sum is aligned.
  if (DIGIT < WIDTH) begin : g_shift
    assign w_acc_next = {w_s, r_acc[WIDTH-1:DIGIT]};
  end else begin : g_single
    assign w_acc_next = w_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, per-slice shifting, and result load on the final slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a     <= '0;
      r_op_nb    <= '0;
      r_acc      <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_diff     <= '0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_op_a   <= a;
      r_op_nb  <= ~b;
      r_carry  <= 1'b1;
      r_cnt    <= '0;
      r_sign_a <= a[WIDTH-1];
      r_sign_b <= b[WIDTH-1];
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_next;
      r_carry <= w_cout;
      r_op_a  <= r_op_a >> DIGIT;
      r_op_nb <= r_op_nb >> DIGIT;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff     <= w_acc_next;
        r_borrow   <= ~w_cout;
        r_overflow <= sub_overflow(r_sign_a, r_sign_b, w_acc_next[WIDTH-1]);
      end
    end
  end

  assign diff     = r_diff;
  assign borrow   = r_borrow;
  assign overflow = r_overflow;

endmodule
